// File: rtl/tv80_bus_pkg.sv
// tv80_bus_pkg: shared FSM and cycle-type encodings for the TV80 bus bridge.
package tv80_bus_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    typedef enum logic [2:0] {CYC_NONE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTA, RFSH} cycle_t;
    localparam logic [7:0] DEFAULT_IDLE_DATA = 8'hFF;
    function automatic logic is_access(cycle_t c);
        return c inside {MEM_RD, MEM_WR, IO_RD, IO_WR};
    endfunction
    function automatic logic is_io(cycle_t c);
        return c inside {IO_RD, IO_WR};
    endfunction
endpackage

// File: rtl/tv80_bus_decode.sv
// tv80_bus_decode: classifies the Z80 strobe set into a cycle type and
// flags the falling edge of a read/write strobe.
module tv80_bus_decode
    import tv80_bus_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   cen,
    input  logic   m1_n,
    input  logic   mreq_n,
    input  logic   iorq_n,
    input  logic   rd_n,
    input  logic   wr_n,
    input  logic   rfsh_n,
    output cycle_t cyc,
    output logic   start
);
    logic strb_idle_q;
    // cleared in reset so a strobe still low when reset lifts is not taken as a new access
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) strb_idle_q <= 1'b0;
        else if (cen) strb_idle_q <= rd_n && wr_n;
    assign start = (!rd_n || !wr_n) && strb_idle_q;
    always_comb
        cyc = (!m1_n && !iorq_n && rd_n) ? INTA :
              (!mreq_n && !rfsh_n)       ? RFSH :
              (!mreq_n && !rd_n)         ? MEM_RD :
              (!mreq_n && !wr_n)         ? MEM_WR :
              (!iorq_n && !rd_n)         ? IO_RD :
              (!iorq_n && !wr_n)         ? IO_WR : CYC_NONE;
endmodule

// File: rtl/tv80_bus_bridge.sv
// tv80_bus_bridge: turns TV80 strobes into a req/ack slave transaction, stretching the CPU with wait_n.
// Define TV80_BRIDGE_TIMEOUT_EN to force completion (bus_err) after TIMEOUT cycles without ack.
module tv80_bus_bridge
    import tv80_bus_pkg::*;
#(
    parameter int unsigned MIN_WAIT  = 0,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  IDLE_DATA = DEFAULT_IDLE_DATA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cen,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    input  logic [7:0]  int_vector,
    output logic        inta,
    output logic        bus_err
);
    state_t     state, state_nx;
    cycle_t     cyc;
    logic       start, access, ack_done, timed_out, done, ack_seen, inta_q;
    logic [3:0] wcnt;
    logic [7:0] rdata_q;

    tv80_bus_decode u_decode (
        .clk(clk), .reset_n(reset_n), .cen(cen), .m1_n(m1_n), .mreq_n(mreq_n),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .cyc(cyc), .start(start)
    );

    assign access   = state == IDLE && start && is_access(cyc);
    assign ack_done = state == BUSY && wcnt == 4'd0 && (bus_ack || ack_seen);
    assign done     = ack_done || timed_out;

`ifdef TV80_BRIDGE_TIMEOUT_EN
    logic [7:0] tcnt;
    assign timed_out = state == BUSY && !ack_done && tcnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) tcnt <= 8'd0;
        else if (cen) tcnt <= state == BUSY ? tcnt + 8'd1 : 8'd0;
`else
    logic [7:0] unused_timeout;
    assign timed_out      = 1'b0;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else if (cen) state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (access ? BUSY : IDLE) :
                   state == BUSY ? (done ? HOLD : BUSY) :
                   (rd_n && wr_n) ? IDLE : HOLD;

    // released in the completion cycle so a zero-wait slave costs exactly one wait state
    always_comb wait_n = !(access || (state == BUSY && !done));

    // runs on every clk so an ack pulse landing on a cen-low cycle is not lost
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ack_seen <= 1'b0;
            rdata_q  <= 8'h00;
        end else if (state != BUSY) begin
            ack_seen <= 1'b0;
        end else if (bus_ack) begin
            ack_seen <= 1'b1;
            rdata_q  <= bus_rdata;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_addr  <= 16'h0000;
            bus_wdata <= 8'h00;
            cpu_di    <= 8'h00;
            inta      <= 1'b0;
            inta_q    <= 1'b0;
            bus_err   <= 1'b0;
            wcnt      <= 4'd0;
        end else if (cen) begin
            inta_q  <= cyc == INTA;
            inta    <= state == IDLE && cyc == INTA && !inta_q;
            bus_err <= timed_out;
            if (state == IDLE && cyc == INTA) cpu_di <= int_vector;
            if (access) begin
                bus_req   <= 1'b1;
                bus_we    <= !wr_n;
                bus_io    <= is_io(cyc);
                bus_addr  <= is_io(cyc) ? {8'h00, A[7:0]} : A;
                bus_wdata <= cpu_dout;
                wcnt      <= 4'(MIN_WAIT);
            end
            if (state == BUSY && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
            if (done) begin
                bus_req <= 1'b0;
                if (!bus_we) cpu_di <= ack_done ? (bus_ack ? bus_rdata : rdata_q) : IDLE_DATA;
            end
        end
endmodule

// File: tb/tb_tv80_bus_bridge.sv
// tb_tv80_bus_bridge: table-driven transfers plus hand-written corner sequences,
// with a request scoreboard checked by a slave model.
module tb_tv80_bus_bridge;
    typedef struct packed {logic we; logic io; logic [15:0] addr; logic [7:0] wdata;} txn_t;
    typedef struct {logic io; logic we; logic [15:0] addr; logic [7:0] wd; logic [7:0] rd; logic [15:0] exp_addr;} vec_t;

    logic        clk = 0, reset_n = 1, cen = 1;
    logic        m1_n = 1, mreq_n = 1, iorq_n = 1, rfsh_n = 1;
    logic        rd_a = 1, wr_a = 1, rd_b = 1, wr_b = 1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00, int_vector = 8'h00;
    logic        ack_a = 0, ack_b = 0;
    logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;
    logic [7:0]  cpu_di_a, cpu_di_b, bus_wdata_a, bus_wdata_b;
    logic [15:0] bus_addr_a, bus_addr_b;
    logic        wait_a, wait_b, bus_req_a, bus_req_b, bus_we_a, bus_we_b, bus_io_a, bus_io_b;
    logic        inta_a, inta_b, bus_err_a, bus_err_b;
    logic        sel_b = 0, wait_sel;

    int   errors = 0, checks = 0, starts = 0, req_cyc = 0, err_cyc = 0;
    txn_t sb[$];
    logic prev_a = 0, prev_b = 0, acked_a = 0, acked_b = 0, slave_en = 1, ack_force = 0;
    logic [7:0] slave_rdata = 8'h00;

    always #5 clk = ~clk;
    assign wait_sel = sel_b ? wait_b : wait_a;

    tv80_bus_bridge dut_a (
        .clk(clk), .reset_n(reset_n), .cen(cen), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_a), .wr_n(wr_a), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di_a),
        .wait_n(wait_a), .bus_req(bus_req_a), .bus_we(bus_we_a), .bus_io(bus_io_a),
        .bus_addr(bus_addr_a), .bus_wdata(bus_wdata_a), .bus_ack(ack_a), .bus_rdata(rdata_a),
        .int_vector(int_vector), .inta(inta_a), .bus_err(bus_err_a)
    );

    tv80_bus_bridge #(.MIN_WAIT(3), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .cen(cen), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_b), .wr_n(wr_b), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di_b),
        .wait_n(wait_b), .bus_req(bus_req_b), .bus_we(bus_we_b), .bus_io(bus_io_b),
        .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b), .bus_ack(ack_b), .bus_rdata(rdata_b),
        .int_vector(int_vector), .inta(inta_b), .bus_err(bus_err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input txn_t got);
        txn_t e;
        starts++;
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_txn", got, e);
        end
    endtask

    // slave model: acks once, in the first cycle a request is visible
    always @(negedge clk) begin
        if (bus_req_a && !prev_a) sb_pop({bus_we_a, bus_io_a, bus_addr_a, bus_wdata_a});
        if (bus_req_b && !prev_b) sb_pop({bus_we_b, bus_io_b, bus_addr_b, bus_wdata_b});
        req_cyc += int'(bus_req_a) + int'(bus_req_b);
        err_cyc += int'(bus_err_a) + int'(bus_err_b);
        ack_a   = (slave_en && bus_req_a && !acked_a) || ack_force;
        ack_b   = slave_en && bus_req_b && !acked_b;
        rdata_a = ack_a ? slave_rdata : ~slave_rdata;
        rdata_b = ack_b ? slave_rdata : ~slave_rdata;
        acked_a = bus_req_a && (acked_a || ack_a);
        acked_b = bus_req_b && (acked_b || ack_b);
        prev_a  = bus_req_a;
        prev_b  = bus_req_b;
    end

    task automatic xfer(input logic b, input logic io, input logic we, input logic m1,
                        input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                        input txn_t exp, output int wlow);
        logic released;
        sel_b = b;
        slave_rdata = rd;
        sb.push_back(exp);
        @(negedge clk);
        A = addr; cpu_dout = wd; m1_n = !m1; mreq_n = io; iorq_n = !io;
        if (b) begin rd_b = we; wr_b = !we; end
        else begin rd_a = we; wr_a = !we; end
        wlow = 0;
        released = 0;
        for (int i = 0; i < 64 && !released; i++) begin
            #2;
            if (wait_sel) released = 1;
            else begin
                wlow++;
                @(negedge clk);
            end
        end
        check("wait_release", released, 1);
        @(negedge clk);
        {m1_n, mreq_n, iorq_n, rd_a, wr_a, rd_b, wr_b} = '1;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        txn_t e;
        int   wl, s0, r0, cnt;
        logic minw;
        vt[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 16'h1234};
        vt[1] = '{1'b1, 1'b1, 16'hBE42, 8'h3C, 8'h00, 16'h0042};
        vt[2] = '{1'b0, 1'b1, 16'hFFFF, 8'h81, 8'h00, 16'hFFFF};
        vt[3] = '{1'b1, 1'b0, 16'h55AA, 8'h00, 8'h5A, 16'h00AA};
        vt[4] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'h3C, 16'h8001};

        #1 reset_n = 0;
        #2;
        check("reset_a", {bus_req_a, bus_we_a, bus_io_a, bus_addr_a, bus_wdata_a, cpu_di_a, inta_a, bus_err_a, wait_a}, 38'h1);
        check("reset_b", {bus_req_b, wait_b, cpu_di_b}, 10'h100);
        @(negedge clk) reset_n = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            s0 = starts; r0 = req_cyc;
            e = '{vt[i].we, vt[i].io, vt[i].exp_addr, vt[i].wd};
            xfer(1'b0, vt[i].io, vt[i].we, 1'b0, vt[i].addr, vt[i].wd, vt[i].rd, e, wl);
            check("wait_cycles", wl, 1);
            check("req_cycles", req_cyc - r0, 1);
            check("req_count", starts - s0, 1);
            if (!vt[i].we) check("read_data", cpu_di_a, vt[i].rd);
        end

        // MIN_WAIT=3: early ack must be retained and complete exactly once
        s0 = starts; r0 = req_cyc;
        e = '{1'b0, 1'b0, 16'h2468, 8'h00};
        xfer(1'b1, 1'b0, 1'b0, 1'b0, 16'h2468, 8'h00, 8'hC3, e, wl);
        check("minwait_wait_cycles", wl, 4);
        check("minwait_req_cycles", req_cyc - r0, 4);
        check("minwait_req_count", starts - s0, 1);
        check("minwait_read_data", cpu_di_b, 8'hC3);

        // opcode fetch followed by refresh
        s0 = starts;
        e = '{1'b0, 1'b0, 16'h0100, 8'h00};
        xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 8'h00, 8'hED, e, wl);
        check("fetch_wait_cycles", wl, 1);
        check("fetch_data", cpu_di_a, 8'hED);
        minw = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = 16'h007F; mreq_n = 0; rfsh_n = 0;
            #2 minw &= wait_a;
        end
        @(negedge clk) {mreq_n, rfsh_n} = 2'b11;
        #2;
        check("refresh_no_wait", minw, 1);
        check("fetch_refresh_req_count", starts - s0, 1);

        // interrupt acknowledge
        s0 = starts; cnt = 0; minw = 1;
        @(negedge clk);
        int_vector = 8'hFE; m1_n = 0; iorq_n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) {m1_n, iorq_n} = 2'b11;
            #2;
            cnt += int'(inta_a);
            minw &= wait_a;
            @(negedge clk);
        end
        check("inta_pulses", cnt, 1);
        check("inta_vector", cpu_di_a, 8'hFE);
        check("inta_no_wait", minw, 1);
        check("inta_no_req", starts - s0, 0);

`ifdef TV80_BRIDGE_TIMEOUT_EN
        slave_en = 0;
        err_cyc = 0;
        e = '{1'b0, 1'b0, 16'h3000, 8'h00};
        xfer(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 8'h00, 8'h00, e, wl);
        check("timeout_wait_cycles", wl, 8);
        check("timeout_idle_data", cpu_di_b, 8'hFF);
        repeat (2) @(negedge clk);
        check("timeout_err_pulses", err_cyc, 1);
        slave_en = 1;
`endif

        // reset mid-BUSY, then a late ack must be ignored
        slave_en = 0;
        sel_b = 0;
        sb.push_back('{1'b0, 1'b0, 16'h4321, 8'h00});
        @(negedge clk);
        A = 16'h4321; mreq_n = 0; rd_a = 0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", {bus_req_a, wait_a}, 2'b10);
        #1 reset_n = 0;
        #1;
        check("reset_mid_busy", {bus_req_a, bus_we_a, bus_io_a, bus_addr_a, bus_wdata_a, cpu_di_a, inta_a, bus_err_a, wait_a}, 38'h1);
        @(negedge clk);
        ack_force = 1;
        reset_n = 1;
        #2 check("late_ack_idle", {bus_req_a, wait_a}, 2'b01);
        @(negedge clk) ack_force = 0;
        #2 check("late_ack_ignored", {bus_req_a, wait_a, cpu_di_a}, 10'h100);
        @(negedge clk) {mreq_n, rd_a} = 2'b11;
        slave_en = 1;
        @(negedge clk);
        e = '{1'b0, 1'b0, 16'h0F0F, 8'h00};
        xfer(1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F, 8'h00, 8'h77, e, wl);
        check("recover_wait_cycles", wl, 1);
        check("recover_read_data", cpu_di_a, 8'h77);

`ifndef TV80_BRIDGE_TIMEOUT_EN
        check("no_bus_err", err_cyc, 0);
`endif
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
